// File: rtl/fpnew_pkg.sv
// Shared FPU configuration constants used by the result-path blocks.
package fpnew_pkg;

  localparam int unsigned NUM_OPGROUPS = 4;

endpackage

// File: rtl/fpnew_order_fifo.sv
// Issue-order tracking FIFO: records the destination channel of each accepted operation.
module fpnew_order_fifo #(
  parameter  int unsigned Depth    = 8,
  parameter  int unsigned Width    = 2,
  localparam int unsigned PtrWidth = $clog2(Depth),
  localparam int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [Width-1:0]    wdata_i,
  input  logic                pop_i,
  output logic [Width-1:0]    head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] count_o
);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrWidth-1:0] wptr_q, wptr_d;
  logic [PtrWidth-1:0] rptr_q, rptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                push, pop;

  function automatic logic [PtrWidth-1:0] wrap_inc(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
  endfunction

  assign full_o  = (cnt_q == CntWidth'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

  // No bypass: a push is refused while full even if a pop happens the same cycle.
  assign push = push_i & ~full_o;
  assign pop  = pop_i & ~empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wrap_inc(wptr_q);
      if (pop)  rptr_d = wrap_inc(rptr_q);
      cnt_d = cnt_q + CntWidth'(push) - CntWidth'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !flush_i));
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop_i && empty_o && !flush_i));

endmodule

// File: rtl/fpnew_ordered_arbiter.sv
// FPU result arbiter: retires channel results in issue order, or round-robin when InOrder=0.
module fpnew_ordered_arbiter
  import fpnew_pkg::*;
#(
  parameter  int unsigned NumIn     = NUM_OPGROUPS,
  parameter  int unsigned Depth     = 8,
  parameter  int unsigned DataWidth = 74,
  parameter  bit          InOrder   = 1'b1,
  localparam int unsigned IdxWidth  = $clog2(NumIn),
  localparam int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [IdxWidth-1:0]             issue_idx_i,
  input  logic [NumIn-1:0]                req_i,
  output logic [NumIn-1:0]                gnt_o,
  input  logic [NumIn-1:0][DataWidth-1:0] data_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [DataWidth-1:0]            data_o,
  output logic [IdxWidth-1:0]             idx_o,
  output logic [CntWidth-1:0]             count_o,
  output logic                            busy_o
);

  assign busy_o = (count_o != '0) | (|req_i);

  if (InOrder) begin : gen_in_order
    logic [IdxWidth-1:0] fifo_head, head;
    logic                fifo_full, fifo_empty;
    logic [CntWidth-1:0] fifo_cnt;

    fpnew_order_fifo #(
      .Depth (Depth),
      .Width (IdxWidth)
    ) i_order_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (issue_valid_i),
      .wdata_i (issue_idx_i),
      .pop_i   (out_valid_o & out_ready_i),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
    );

    // Only the oldest outstanding channel may be served; other requests wait.
    assign head          = fifo_empty ? '0 : fifo_head;
    assign out_valid_o   = ~fifo_empty & req_i[head];
    assign data_o        = fifo_empty ? '0 : data_i[head];
    assign idx_o         = head;
    assign count_o       = fifo_cnt;
    assign issue_ready_o = ~fifo_full;

    always_comb begin
      gnt_o = '0;
      if (!fifo_empty) gnt_o[head] = out_ready_i;
    end

    a_idx_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
      issue_valid_i |-> (int'(issue_idx_i) < int'(NumIn)));
  end else begin : gen_round_robin
    logic [IdxWidth-1:0] rr_q, rr_d;
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
    logic [IdxWidth-1:0] sel, cand;
    logic                found;
    logic                unused_issue;

    assign unused_issue = ^{issue_valid_i, issue_idx_i};

    // A stalled grant is locked so the presented result cannot change under the FPU output.
    always_comb begin
      sel   = rr_q;
      cand  = rr_q;
      found = 1'b0;
      for (int unsigned i = 0; i < NumIn; i++) begin
        cand = IdxWidth'((int'(rr_q) + i) % NumIn);
        if (!found && req_i[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
      if (lock_q) begin
        sel   = lock_idx_q;
        found = req_i[lock_idx_q];
      end
    end

    assign out_valid_o   = found;
    assign data_o        = found ? data_i[sel] : '0;
    assign idx_o         = found ? sel : '0;
    assign count_o       = '0;
    assign issue_ready_o = 1'b1;

    always_comb begin
      gnt_o      = '0;
      gnt_o[sel] = found & out_ready_i;
      lock_d     = found & ~out_ready_i;
      lock_idx_d = sel;
      rr_d       = rr_q;
      if (found && out_ready_i)
        rr_d = (sel == IdxWidth'(NumIn - 1)) ? '0 : sel + IdxWidth'(1);
      if (flush_i) begin
        lock_d = 1'b0;
        rr_d   = '0;
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rr_q       <= '0;
        lock_q     <= 1'b0;
        lock_idx_q <= '0;
      end else begin
        rr_q       <= rr_d;
        lock_q     <= lock_d;
        lock_idx_q <= lock_idx_d;
      end
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

endmodule

// File: tb/tb_fpnew_ordered_arbiter.sv
// Scoreboard bench: ordered instance (A) and round-robin instance (B) share clock and reset.
module tb_fpnew_ordered_arbiter;
  localparam int NI = 4;
  localparam int DP = 8;
  localparam int DW = 74;

  typedef struct packed {
    logic [1:0]    idx;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                   a_flush, a_issue_valid, a_issue_ready, a_out_valid, a_out_ready, a_busy;
  logic [1:0]             a_issue_idx, a_idx;
  logic [NI-1:0]          a_req, a_gnt;
  logic [NI-1:0][DW-1:0]  a_data_i;
  logic [DW-1:0]          a_data_o;
  logic [3:0]             a_count;

  logic                   b_flush, b_issue_valid, b_issue_ready, b_out_valid, b_out_ready, b_busy;
  logic [1:0]             b_issue_idx, b_idx;
  logic [NI-1:0]          b_req, b_gnt, b_reload;
  logic [NI-1:0][DW-1:0]  b_data_i;
  logic [DW-1:0]          b_data_o;
  logic [3:0]             b_count;

  fpnew_ordered_arbiter #(.NumIn(NI), .Depth(DP), .DataWidth(DW), .InOrder(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .issue_valid_i(a_issue_valid),
    .issue_ready_o(a_issue_ready), .issue_idx_i(a_issue_idx), .req_i(a_req), .gnt_o(a_gnt),
    .data_i(a_data_i), .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .data_o(a_data_o),
    .idx_o(a_idx), .count_o(a_count), .busy_o(a_busy)
  );

  fpnew_ordered_arbiter #(.NumIn(NI), .Depth(DP), .DataWidth(DW), .InOrder(1'b0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .issue_valid_i(b_issue_valid),
    .issue_ready_o(b_issue_ready), .issue_idx_i(b_issue_idx), .req_i(b_req), .gnt_o(b_gnt),
    .data_i(b_data_i), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .data_o(b_data_o),
    .idx_o(b_idx), .count_o(b_count), .busy_o(b_busy)
  );

  int   checks = 0;
  int   errors = 0;
  int   tag_ctr = 0;
  bit   auto_present = 1'b0;
  exp_t exp_a[$];
  exp_t exp_b[$];
  int   chan_q[NI][$];

  function automatic logic [DW-1:0] mk(input int ch, input int tag);
    logic [1:0] c2;
    logic [7:0] t8;
    c2 = ch[1:0];
    t8 = tag[7:0];
    return {c2, t8, 64'hC0DE_0000_0000_0000 | 64'(tag)};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic present(input int ch);
    if (chan_q[ch].size() > 0) begin
      a_data_i[ch] = mk(ch, chan_q[ch].pop_front());
      a_req[ch]    = 1'b1;
    end
  endtask

  // One clock: channels drop a granted request after the handshake edge, then refill.
  task automatic tick();
    logic       hs_a, hs_b;
    logic [1:0] ia, ib;
    @(negedge clk);
    hs_a = a_out_valid & a_out_ready;
    ia   = a_idx;
    hs_b = b_out_valid & b_out_ready;
    ib   = b_idx;
    @(posedge clk);
    #1;
    if (hs_a) a_req[ia] = 1'b0;
    if (hs_b) begin
      if (b_reload[ib]) b_reload[ib] = 1'b0;
      else b_req[ib] = 1'b0;
    end
    if (auto_present)
      for (int ch = 0; ch < NI; ch++)
        if (!a_req[ch]) present(ch);
  endtask

  task automatic issue(input int ch);
    exp_t e;
    tag_ctr++;
    e.idx  = ch[1:0];
    e.data = mk(ch, tag_ctr);
    exp_a.push_back(e);
    chan_q[ch].push_back(tag_ctr);
    a_issue_valid = 1'b1;
    a_issue_idx   = ch[1:0];
    tick();
    a_issue_valid = 1'b0;
  endtask

  task automatic drain();
    auto_present = 1'b1;
    a_out_ready  = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (exp_a.size() == 0 && a_count == 0 && a_req == '0) break;
      tick();
    end
    chk("drain_queue_empty", DW'(exp_a.size()), DW'(0));
    chk("drain_count_zero", DW'(a_count), DW'(0));
  endtask

  task automatic push_b(input int ch);
    exp_t e;
    e.idx  = ch[1:0];
    e.data = b_data_i[ch];
    exp_b.push_back(e);
  endtask

  task automatic clear_a();
    exp_a.delete();
    for (int ch = 0; ch < NI; ch++) chan_q[ch].delete();
    a_req = '0;
  endtask

  initial begin
    int issued;
    a_flush = 0; a_issue_valid = 0; a_issue_idx = 0; a_req = '0; a_out_ready = 0;
    b_flush = 0; b_issue_valid = 0; b_issue_idx = 0; b_req = '0; b_out_ready = 0; b_reload = '0;
    for (int ch = 0; ch < NI; ch++) begin
      a_data_i[ch] = '0;
      b_data_i[ch] = mk(ch, 8'hB0 + ch);
    end

    fork
      forever begin : monitor
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
          chk("count_le_depth", DW'(a_count <= 4'(DP)), DW'(1));
          if (a_out_valid && a_out_ready) begin
            if (exp_a.size() == 0) chk("a_unexpected_output", DW'(a_idx), DW'(4));
            else begin
              e = exp_a.pop_front();
              chk("a_out_idx", DW'(a_idx), DW'(e.idx));
              chk("a_out_data", a_data_o, e.data);
            end
          end
          if (b_out_valid && b_out_ready) begin
            if (exp_b.size() == 0) chk("b_unexpected_output", DW'(b_idx), DW'(4));
            else begin
              e = exp_b.pop_front();
              chk("b_out_idx", DW'(b_idx), DW'(e.idx));
              chk("b_out_data", b_data_o, e.data);
            end
          end
        end
      end
      begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_issue_ready", DW'(a_issue_ready), DW'(1));
    chk("rst_out_valid", DW'(a_out_valid), DW'(0));
    chk("rst_gnt", DW'(a_gnt), DW'(0));
    chk("rst_count", DW'(a_count), DW'(0));
    chk("rst_idx", DW'(a_idx), DW'(0));
    chk("rst_data", a_data_o, DW'(0));
    chk("rst_busy", DW'(a_busy), DW'(0));

    // Order: ch2 issued before ch0; ch0 answers first but must wait.
    a_out_ready = 1'b1;
    issue(2);
    issue(0);
    tick();
    present(0);
    for (int c = 3; c <= 5; c++) begin
      #1;
      chk("order_gnt0_low", DW'(a_gnt[0]), DW'(0));
      chk("order_hold_valid", DW'(a_out_valid), DW'(0));
      tick();
    end
    present(2);
    #1;
    chk("order_c6_gnt0_low", DW'(a_gnt[0]), DW'(0));
    chk("order_c6_valid", DW'(a_out_valid), DW'(1));
    chk("order_c6_idx", DW'(a_idx), DW'(2));
    tick();
    #1;
    chk("order_c7_valid", DW'(a_out_valid), DW'(1));
    chk("order_c7_idx", DW'(a_idx), DW'(0));
    chk("order_c7_gnt", DW'(a_gnt), DW'(4'b0001));
    tick();
    #1;
    chk("order_done_count", DW'(a_count), DW'(0));
    chk("order_done_busy", DW'(a_busy), DW'(0));

    // Full: eight outstanding, then one pop frees a slot.
    a_out_ready = 1'b0;
    for (int i = 0; i < DP; i++) issue(i % NI);
    #1;
    chk("full_issue_ready", DW'(a_issue_ready), DW'(0));
    chk("full_count", DW'(a_count), DW'(DP));
    for (int ch = 0; ch < NI; ch++) present(ch);
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    #1;
    chk("after_pop_issue_ready", DW'(a_issue_ready), DW'(1));
    chk("after_pop_count", DW'(a_count), DW'(DP - 1));
    drain();

    // Wrap: random channels with random output stalls.
    auto_present = 1'b1;
    issued = 0;
    for (int c = 0; c < 400 && issued < 20; c++) begin
      a_out_ready = 1'($urandom_range(1));
      if (a_issue_ready) begin
        issue(int'($urandom_range(NI - 1)));
        issued++;
      end else tick();
    end
    chk("wrap_issued", DW'(issued), DW'(20));
    drain();

    // Flush with a simultaneous push.
    auto_present = 1'b0;
    a_out_ready  = 1'b0;
    issue(0); issue(1); issue(2); issue(3); issue(0);
    #1;
    chk("flush_pre_count", DW'(a_count), DW'(5));
    a_flush       = 1'b1;
    a_issue_valid = 1'b1;
    a_issue_idx   = 2'd1;
    tick();
    a_flush       = 1'b0;
    a_issue_valid = 1'b0;
    clear_a();
    a_req = '1;
    #1;
    chk("flush_count", DW'(a_count), DW'(0));
    chk("flush_out_valid", DW'(a_out_valid), DW'(0));
    chk("flush_issue_ready", DW'(a_issue_ready), DW'(1));
    a_req = '0;
    issue(3);
    drain();

    // Asynchronous reset with results pending.
    auto_present = 1'b0;
    a_out_ready  = 1'b0;
    issue(3); issue(1); issue(2);
    present(3);
    #1;
    chk("prerst_valid", DW'(a_out_valid), DW'(1));
    chk("prerst_idx", DW'(a_idx), DW'(3));
    chk("prerst_count", DW'(a_count), DW'(3));
    #1;
    rst_n       = 1'b0;
    a_out_ready = 1'b1;
    #1;
    chk("async_rst_valid", DW'(a_out_valid), DW'(0));
    chk("async_rst_gnt", DW'(a_gnt), DW'(0));
    chk("async_rst_count", DW'(a_count), DW'(0));
    chk("async_rst_issue_ready", DW'(a_issue_ready), DW'(1));
    clear_a();
    a_out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    issue(1);
    drain();

    // Round-robin: stall on ch0, then 0,1,3 and ch0's second result.
    b_req       = 4'b1011;
    b_reload    = 4'b0001;
    b_out_ready = 1'b0;
    push_b(0); push_b(1); push_b(3); push_b(0);
    #1;
    chk("rr_stall_valid", DW'(b_out_valid), DW'(1));
    chk("rr_stall_idx0", DW'(b_idx), DW'(0));
    tick();
    #1;
    chk("rr_stall_idx1", DW'(b_idx), DW'(0));
    chk("rr_stall_gnt", DW'(b_gnt), DW'(0));
    tick();
    b_out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_b.size() > 0; c++) tick();
    chk("rr_seq_done", DW'(exp_b.size()), DW'(0));
    chk("rr_count", DW'(b_count), DW'(0));
    chk("rr_issue_ready", DW'(b_issue_ready), DW'(1));

    // Lock: stalled grant on ch3 must survive ch1 arriving at higher priority.
    b_out_ready = 1'b0;
    b_req       = 4'b1000;
    tick();
    b_req = 4'b1010;
    #1;
    chk("rr_lock_idx", DW'(b_idx), DW'(3));
    chk("rr_lock_gnt", DW'(b_gnt), DW'(0));
    push_b(3); push_b(1);
    b_out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_b.size() > 0; c++) tick();
    chk("rr_lock_done", DW'(exp_b.size()), DW'(0));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
